// File: rtl/traffic_pkg.sv
// Shared traffic-light constants: light codes, phase encodings and
// countdown width, used by the phase sequencer and the display scanner.
package traffic_pkg;

   localparam int CW = 7;

   localparam logic [3:0] RED   = 4'd0;
   localparam logic [3:0] LEFT  = 4'd1;
   localparam logic [3:0] YEL_L = 4'd2;
   localparam logic [3:0] GREEN = 4'd3;
   localparam logic [3:0] YEL_G = 4'd4;

   typedef enum logic [2:0] {
      P0, P1, P2, P3, P4, P5, P6, P7
   } phase_e;

endpackage

// File: rtl/tick_prescaler.sv
// 1 s tick prescaler: counts 0..TICK_DIV-1 while en, held at 0 otherwise.
// Ports: clk, rst (async, active-low), en; tick pulses at the last count.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] MAX = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Gating with en makes a same-cycle emergency swallow the tick.
   assign tick = en && (cnt_q == MAX);

   always_comb begin
      cnt_d = '0;
      if (en && cnt_q != MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase sequencer with registered light codes and
// seconds countdowns. Ports: clk, rst (async low), emerg; Astate, Bstate,
// Acountdown, Bcountdown, tick.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int T_GREEN  = 25,
   parameter int T_YELLOW = 3,
   parameter int T_LEFT   = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          emerg,
   output logic [3:0]    Astate,
   output logic [3:0]    Bstate,
   output logic [CW-1:0] Acountdown,
   output logic [CW-1:0] Bcountdown,
   output logic          tick
);

   localparam int HALF = T_GREEN + 2 * T_YELLOW + T_LEFT;

   if (HALF > 99 || TICK_DIV < 2 ||
       T_GREEN < 1 || T_YELLOW < 1 || T_LEFT < 1) begin : g_bad_cfg
      $error("traffic_phase_ctrl: bad timing parameters");
   end

   localparam logic [CW-1:0] DG = CW'(T_GREEN);
   localparam logic [CW-1:0] DY = CW'(T_YELLOW);
   localparam logic [CW-1:0] DL = CW'(T_LEFT);

   phase_e        phase_q, phase_d, phase_nx;
   logic [CW-1:0] rem_q, rem_d;
   logic [3:0]    as_q, as_d, bs_q, bs_d;
   logic [CW-1:0] ac_q, ac_d, bc_q, bc_d;
   logic [3:0]    act_code;
   logic [CW-1:0] tail, red_cd;

   // Position within a half-cycle alone fixes duration and codes.
   function automatic logic [CW-1:0] dur_of(input phase_e p);
      logic [CW-1:0] d;
      unique case (p[1:0])
         2'd0:    d = DG;
         2'd2:    d = DL;
         default: d = DY;
      endcase
      return d;
   endfunction

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (!emerg),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= P0;
         rem_q   <= DG;
      end else begin
         phase_q <= phase_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      phase_nx = phase_e'(phase_q + 3'd1);
      phase_d  = phase_q;
      rem_d    = rem_q;
      if (tick) begin
         if (rem_q > 1) begin
            rem_d = rem_q - 1'b1;
         end else begin
            phase_d = phase_nx;
            rem_d   = dur_of(phase_nx);
         end
      end
   end

   // Red road waits for the rest of the other road's half-cycle.
   always_comb begin
      act_code = GREEN;
      tail     = '0;
      unique case (phase_q[1:0])
         2'd0: begin
            act_code = GREEN;
            tail     = DY + DL + DY;
         end
         2'd1: begin
            act_code = YEL_G;
            tail     = DL + DY;
         end
         2'd2: begin
            act_code = LEFT;
            tail     = DY;
         end
         default: begin
            act_code = YEL_L;
            tail     = '0;
         end
      endcase
      red_cd = rem_q + tail;
      if (!phase_q[2]) begin
         as_d = act_code;
         bs_d = RED;
         ac_d = rem_q;
         bc_d = red_cd;
      end else begin
         as_d = RED;
         bs_d = act_code;
         ac_d = red_cd;
         bc_d = rem_q;
      end
      if (emerg) begin
         as_d = RED;
         bs_d = RED;
         ac_d = '0;
         bc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         as_q <= GREEN;
         bs_q <= RED;
         ac_q <= DG;
         bc_q <= CW'(HALF);
      end else begin
         as_q <= as_d;
         bs_q <= bs_d;
         ac_q <= ac_d;
         bc_q <= bc_d;
      end
   end

   assign Astate     = as_q;
   assign Bstate     = bs_q;
   assign Acountdown = ac_q;
   assign Bcountdown = bc_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: vector table for the normal
// cycle plus sequences for emergency, tick-collision and async reset.
module tb_traffic_phase_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       emerg = 1'b0;
   logic [3:0] Astate, Bstate;
   logic [6:0] Acountdown, Bcountdown;
   logic       tick;

   int n_vec = 0;
   int n_bad = 0;
   int edges = 0;

   typedef struct {
      int at;
      int as;
      int ac;
      int bs;
      int bc;
   } vec_t;

   vec_t tbl[10];

   traffic_phase_ctrl #(
      .TICK_DIV (4),
      .T_GREEN  (5),
      .T_YELLOW (2),
      .T_LEFT   (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .emerg      (emerg),
      .Astate     (Astate),
      .Bstate     (Bstate),
      .Acountdown (Acountdown),
      .Bcountdown (Bcountdown),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      edges += n;
   endtask

   task automatic chk(input string nm, input int as, input int ac,
                      input int bs, input int bc);
      n_vec++;
      if (Astate !== 4'(as) || Acountdown !== 7'(ac) ||
          Bstate !== 4'(bs) || Bcountdown !== 7'(bc)) begin
         n_bad++;
         $display("FAIL %s: got A=%0d/%0d B=%0d/%0d need A=%0d/%0d B=%0d/%0d",
                  nm, Astate, Acountdown, Bstate, Bcountdown,
                  as, ac, bs, bc);
      end
   endtask

   task automatic chk_tick(input string nm, input logic exp);
      n_vec++;
      if (tick !== exp) begin
         n_bad++;
         $display("FAIL %s: tick=%b need %b", nm, tick, exp);
      end
   endtask

   initial begin
      tbl[0] = '{1,   3, 5,  0, 12};
      tbl[1] = '{5,   3, 4,  0, 11};
      tbl[2] = '{21,  4, 2,  0, 7};
      tbl[3] = '{29,  1, 3,  0, 5};
      tbl[4] = '{41,  2, 2,  0, 2};
      tbl[5] = '{45,  2, 1,  0, 1};
      tbl[6] = '{49,  0, 12, 3, 5};
      tbl[7] = '{53,  0, 11, 3, 4};
      tbl[8] = '{97,  3, 5,  0, 12};
      tbl[9] = '{129, 1, 2,  0, 4};

      step(2);
      chk("reset", 3, 5, 0, 12);
      chk_tick("reset_tick", 1'b0);
      rst = 1'b1;
      edges = 0;

      step(2);
      chk_tick("no_tick_e2", 1'b0);
      step(1);
      chk_tick("first_tick_e3", 1'b1);

      foreach (tbl[i]) begin
         step(tbl[i].at - edges);
         chk($sformatf("vec%0d", i), tbl[i].as, tbl[i].ac,
             tbl[i].bs, tbl[i].bc);
      end

      // Emergency hold mid-P2 (rem=2).
      emerg = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(1);
         chk($sformatf("emerg%0d", k), 0, 0, 0, 0);
         chk_tick($sformatf("emerg_tick%0d", k), 1'b0);
      end
      emerg = 1'b0;
      step(1);
      chk("emerg_release", 1, 2, 0, 4);
      step(1);
      chk_tick("rel_no_tick", 1'b0);
      step(1);
      chk_tick("rel_tick", 1'b1);
      step(2);
      chk("rel_after_tick", 1, 1, 0, 3);

      // Emergency raised in the tick cycle.
      step(2);
      chk_tick("coll_tick", 1'b1);
      emerg = 1'b1;
      #1;
      chk_tick("coll_tick_killed", 1'b0);
      step(3);
      chk("coll_hold", 0, 0, 0, 0);
      emerg = 1'b0;
      step(1);
      chk("coll_release", 1, 1, 0, 3);
      step(4);
      chk("coll_next", 2, 2, 0, 2);

      // Run into P5 (rem=2), then async reset between edges.
      step(28);
      chk("p5", 0, 7, 4, 2);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", 3, 5, 0, 12);
      chk_tick("async_rst_tick", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step(1);
      chk("post_rst", 3, 5, 0, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
